dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side end of the core's data-memory port: accepts load/store requests, models a word array with byte lanes.
//  Handshaked, fixed-latency responder so the core can move from a zero-wait-state dmem to a stalling one.
//  Does RISC-V load/store width selection, sign/zero extension and alignment checks. Sits between core and array.
// PARAMETERS
//  WIDTH    32  data width; only 32 supported (4 byte lanes)
//  DADDR    10  byte-address width; array depth = 2**(DADDR-2) words
//  LATENCY  2   cycles from request accept to access commit; legal range 1..15
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      synchronous, active-high reset
//  req_valid   in   1      request present
//  req_ready   out  1      responder can accept; high only in IDLE
//  req_we      in   1      1 = store, 0 = load
//  req_funct3  in   3      RV32I load/store funct3 (size/sign)
//  req_addr    in   DADDR  byte address
//  req_wdata   in   WIDTH  store data, right-aligned (rs2)
//  rsp_valid   out  1      response present; held until rsp_ready
//  rsp_ready   in   1      core accepts response
//  rsp_rdata   out  WIDTH  load result, extended; 0 for stores and errors
//  rsp_err     out  1      misaligned or illegal funct3; valid with rsp_valid
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Array contents are not reset.
//  FSM IDLE->WAIT on req_valid&&req_ready. Latch we, funct3, addr, wdata. Load counter with LATENCY-1.
//  WAIT: counter decrements each cycle. Access commits on the edge where counter==0: store writes array, load registers data.
//   Same edge: rsp_rdata/rsp_err registered, state->RESP.
//  RESP: rsp_valid=1, outputs stable until rsp_ready. On rsp_valid&&rsp_ready -> IDLE; next accept earliest the following cycle.
//  Latency: LATENCY=1 gives accept at edge N, commit and rsp_valid after edge N+1.
//  Word index = addr[DADDR-1:2], so the full byte space maps, no wrap logic needed. Lane = addr[1:0].
//  Loads: LB lane byte sign-ext, LBU zero-ext. LH/LHU use half addr[1], sign/zero-ext. LW whole word.
//  Stores: SB writes byte lane with wdata[7:0]. SH writes half lane with wdata[15:0]. SW writes all 4 lanes.
//   Other lanes unchanged.
//  Error: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0. Also illegal funct3 (load 3/6/7, store 3..7).
//   On error: no array write, rsp_rdata=0, rsp_err=1, same latency as a good access.
//  req_* ignored outside IDLE. A request in the cycle rsp completes is not accepted (req_ready=0 in RESP).
//  Reset mid-operation (WAIT or RESP): abort to IDLE. A store not yet committed is discarded; committed stores remain.
//  Load after store to same word sees stored data (strict in-order, one outstanding).
// STRUCTURE
//  lib_pkg additions: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
//   Also typedef enum logic[1:0] {RSP_IDLE, RSP_WAIT, RSP_RESP} dmem_rsp_state_t.
//  Sub-module mem_lane_fmt (combinational), used by dmem_responder:
//   inputs funct3, addr[1:0], rdata word, wdata.
//   outputs byte-enable[3:0], lane-shifted wdata, extended load value, misalign/illegal flag.
//  Top holds FSM, counter, request latches, array (reg [31:0] mem[2**(DADDR-2)]), response regs.
// TESTING
//  Reset then idle: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 for 5 cycles.
//  SW 0xDEADBEEF @0x010, LATENCY=2, rsp_ready=1:
//   req_ready low 3 cycles, rsp_valid 1 cycle, err=0. Then LW @0x010 -> 0xDEADBEEF.
//  After above: LB @0x011 -> 0xFFFFFFBE. LBU @0x011 -> 0x000000BE. LH @0x012 -> 0xFFFFDEAD. LHU @0x012 -> 0x0000DEAD.
//  SB 0x55 @0x013, SH 0x1234 @0x010, then LW @0x010 -> 0x55AD1234.
//  Errors: LW @0x012, SH @0x011, funct3=3 load -> rsp_err=1, rdata=0. Following LW @0x010 still 0x55AD1234.
//  Backpressure/reset: rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata held.
//   SW @0x020 with reset pulsed in WAIT before commit -> IDLE next cycle; LW @0x020 returns prior contents.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder slice:
//   - RV32I load/store funct3 encodings (size and sign selection)
//   - responder FSM state type
//   - byte-lane count of the 32-bit data path
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

   // RV32I funct3 encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte lanes in one 32-bit word
   localparam int LANES = 4;

   // Responder FSM: idle, counting down to commit, presenting the response
   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_WAIT = 2'd1,
      RSP_RESP = 2'd2
   } dmem_rsp_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between the core (master) and the data-memory
//   responder (slave).
//   Request : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// ---------------------------------------------------------------------------
interface dmem_responder_if #(
   parameter int WIDTH = 32,
   parameter int DADDR = 10
);

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [2:0]       req_funct3;
   logic [DADDR-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;

   // Core side drives requests and accepts responses
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   // Memory side accepts requests and drives responses
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_responder_mem_lane_fmt.sv
// ---------------------------------------------------------------------------
// mem_lane_fmt
//   Purely combinational byte-lane formatter for RV32I loads and stores.
//   Ports:
//     we_i        1 = store, 0 = load
//     funct3_i    RV32I size/sign selector
//     addrLo_i    byte offset within the word
//     rdata_i     raw word read from the array
//     wdata_i     right-aligned store data
//     be_o        byte enables for the array write (0 on loads and errors)
//     wdataSh_o   store data replicated onto every candidate lane
//     rdataExt_o  extended load value (0 on stores and errors)
//     err_o       misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module mem_lane_fmt
   import dmem_responder_pkg::*;
(
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addrLo_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdataSh_o,
   output logic [31:0] rdataExt_o,
   output logic        err_o
);

   logic [7:0]  laneByte;
   logic [15:0] laneHalf;

   // Pick the addressed byte and half out of the raw word
   always_comb begin
      laneByte = rdata_i[7:0];
      case (addrLo_i)
         2'd0: laneByte = rdata_i[7:0];
         2'd1: laneByte = rdata_i[15:8];
         2'd2: laneByte = rdata_i[23:16];
         2'd3: laneByte = rdata_i[31:24];
         default: laneByte = rdata_i[7:0];
      endcase
      laneHalf = addrLo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Legality: halves need even addresses, words need word alignment, and
   // stores only have the three signed-style encodings
   always_comb begin
      err_o = 1'b0;
      case (funct3_i)
         F3_B:  err_o = 1'b0;
         F3_H:  err_o = addrLo_i[0];
         F3_W:  err_o = (addrLo_i != 2'd0);
         F3_BU: err_o = we_i;
         F3_HU: err_o = we_i | addrLo_i[0];
         default: err_o = 1'b1;
      endcase
   end

   // Store side: the data is replicated across lanes so the byte enables
   // alone decide which lanes change
   always_comb begin
      be_o      = 4'b0000;
      wdataSh_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            be_o      = 4'b0001 << addrLo_i;
            wdataSh_o = {4{wdata_i[7:0]}};
         end
         F3_H: begin
            be_o      = addrLo_i[1] ? 4'b1100 : 4'b0011;
            wdataSh_o = {2{wdata_i[15:0]}};
         end
         F3_W: begin
            be_o      = 4'b1111;
            wdataSh_o = wdata_i;
         end
         default: begin
            be_o      = 4'b0000;
            wdataSh_o = wdata_i;
         end
      endcase
      if (!we_i || err_o) begin
         be_o = 4'b0000;
      end
   end

   // Load side: sign or zero extension; stores and errors return zero
   always_comb begin
      rdataExt_o = 32'd0;
      case (funct3_i)
         F3_B:  rdataExt_o = {{24{laneByte[7]}}, laneByte};
         F3_BU: rdataExt_o = {24'd0, laneByte};
         F3_H:  rdataExt_o = {{16{laneHalf[15]}}, laneHalf};
         F3_HU: rdataExt_o = {16'd0, laneHalf};
         F3_W:  rdataExt_o = rdata_i;
         default: rdataExt_o = 32'd0;
      endcase
      if (we_i || err_o) begin
         rdataExt_o = 32'd0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Fixed-latency, handshaked data-memory responder with a byte-lane word
//   array. One request outstanding; the access commits LATENCY cycles after
//   it is accepted and the response is held until the core takes it.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; aborts any access not yet committed
//     bus    dmem_responder_if slave modport (request and response channels)
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DADDR   = 10,
   parameter int LATENCY = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int         DEPTH    = 2 ** (DADDR - 2);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   dmem_rsp_state_t  state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             reqWe_q, reqWe_d;
   logic [2:0]       reqF3_q, reqF3_d;
   logic [DADDR-1:0] reqAddr_q, reqAddr_d;
   logic [31:0]      reqWdata_q, reqWdata_d;
   logic [31:0]      rspRdata_q, rspRdata_d;
   logic             rspErr_q, rspErr_d;
   logic             commit;

   logic [31:0]      mem [DEPTH];
   logic [31:0]      memWord;
   logic [3:0]       fmtBe;
   logic [31:0]      fmtWdata;
   logic [31:0]      fmtRdata;
   logic             fmtErr;

   // The latched address selects the word; the formatter works on the lane
   assign memWord = mem[reqAddr_q[DADDR-1:2]];

   mem_lane_fmt u_fmt (
      .we_i       (reqWe_q),
      .funct3_i   (reqF3_q),
      .addrLo_i   (reqAddr_q[1:0]),
      .rdata_i    (memWord),
      .wdata_i    (reqWdata_q),
      .be_o       (fmtBe),
      .wdataSh_o  (fmtWdata),
      .rdataExt_o (fmtRdata),
      .err_o      (fmtErr)
   );

   assign bus.req_ready = (state_q == RSP_IDLE);
   assign bus.rsp_valid = (state_q == RSP_RESP);
   assign bus.rsp_rdata = rspRdata_q;
   assign bus.rsp_err   = rspErr_q;

   // Next-state logic: accept in IDLE, count down in WAIT and commit when the
   // counter reaches zero, then hold the response until the core takes it
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reqWe_d    = reqWe_q;
      reqF3_d    = reqF3_q;
      reqAddr_d  = reqAddr_q;
      reqWdata_d = reqWdata_q;
      rspRdata_d = rspRdata_q;
      rspErr_d   = rspErr_q;
      commit     = 1'b0;
      case (state_q)
         RSP_IDLE: begin
            if (bus.req_valid) begin
               state_d    = RSP_WAIT;
               cnt_d      = CNT_INIT;
               reqWe_d    = bus.req_we;
               reqF3_d    = bus.req_funct3;
               reqAddr_d  = bus.req_addr;
               reqWdata_d = bus.req_wdata[31:0];
            end
         end
         RSP_WAIT: begin
            if (cnt_q == 4'd0) begin
               commit     = 1'b1;
               state_d    = RSP_RESP;
               rspRdata_d = fmtRdata;
               rspErr_d   = fmtErr;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RSP_RESP: begin
            if (bus.rsp_ready) begin
               state_d = RSP_IDLE;
            end
         end
         default: state_d = RSP_IDLE;
      endcase
   end

   // Control and response registers; reset drops straight back to IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RSP_IDLE;
         cnt_q      <= 4'd0;
         reqWe_q    <= 1'b0;
         reqF3_q    <= 3'd0;
         reqAddr_q  <= '0;
         reqWdata_q <= 32'd0;
         rspRdata_q <= 32'd0;
         rspErr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         reqWe_q    <= reqWe_d;
         reqF3_q    <= reqF3_d;
         reqAddr_q  <= reqAddr_d;
         reqWdata_q <= reqWdata_d;
         rspRdata_q <= rspRdata_d;
         rspErr_q   <= rspErr_d;
      end
   end

   // Array write port: contents survive reset, but a reset on the commit
   // edge still suppresses the write so an aborted store never lands
   always_ff @(posedge clk) begin
      if (commit && !reset) begin
         for (int i = 0; i < LANES; i++) begin
            if (fmtBe[i]) begin
               mem[reqAddr_q[DADDR-1:2]][8*i +: 8] <= fmtWdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder (LATENCY=2, DADDR=10) with hand-computed
//   expected load values, latency, handshake, error, backpressure and
//   mid-access reset cases.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int LAT = 2;

   logic clk;
   logic reset;
   int   assertions;
   int   failures;

   dmem_responder_if #(.WIDTH(32), .DADDR(10)) bus ();

   dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it and report any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertions++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one request from a negedge, wait for the response, check latency,
   // data and error, optionally stall the response for hold cycles, and
   // return at the negedge after the response has been taken
   task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                                input logic [9:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input logic expErr,
                                input int hold);
      int waitCycles;
      bus.rsp_ready = (hold == 0);
      checkOutput({tag, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      waitCycles = 0;
      @(negedge clk);
      while (!bus.rsp_valid && waitCycles < 20) begin
         waitCycles++;
         @(negedge clk);
      end
      if (!bus.rsp_valid) begin
         checkOutput({tag, "/timeout"}, 32'd0, 32'd1);
         bus.rsp_ready = 1'b1;
         return;
      end
      checkOutput({tag, "/latency"}, 32'(waitCycles), 32'(LAT));
      checkOutput({tag, "/rdata"}, bus.rsp_rdata, expRdata);
      checkOutput({tag, "/err"}, {31'd0, bus.rsp_err}, {31'd0, expErr});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput({tag, "/held_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
         checkOutput({tag, "/held_rdata"}, bus.rsp_rdata, expRdata);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput({tag, "/rsp_done"}, {31'd0, bus.rsp_valid}, 32'd0);
   endtask

   // Directed sequence
   initial begin
      assertions     = 0;
      failures       = 0;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 10'd0;
      bus.req_wdata  = 32'd0;
      bus.rsp_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         checkOutput("reset/req_ready", {31'd0, bus.req_ready}, 32'd1);
         checkOutput("reset/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
         checkOutput("reset/rsp_rdata", bus.rsp_rdata, 32'd0);
         checkOutput("reset/rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
         @(negedge clk);
      end

      // Word store and readback, then sub-word loads of the same word
      applyStimulus("SW_10",  1'b1, F3_W,  10'h010, 32'hDEADBEEF, 32'h0,        1'b0, 0);
      applyStimulus("LW_10",  1'b0, F3_W,  10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 0);
      applyStimulus("LB_11",  1'b0, F3_B,  10'h011, 32'h0,        32'hFFFFFFBE, 1'b0, 0);
      applyStimulus("LBU_11", 1'b0, F3_BU, 10'h011, 32'h0,        32'h000000BE, 1'b0, 0);
      applyStimulus("LH_12",  1'b0, F3_H,  10'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 0);
      applyStimulus("LHU_12", 1'b0, F3_HU, 10'h012, 32'h0,        32'h0000DEAD, 1'b0, 0);
      applyStimulus("LB_10",  1'b0, F3_B,  10'h010, 32'h0,        32'hFFFFFFEF, 1'b0, 0);

      // Partial stores merge into the word
      applyStimulus("SB_13",  1'b1, F3_B,  10'h013, 32'hAAAAAA55, 32'h0,        1'b0, 0);
      applyStimulus("SH_10",  1'b1, F3_H,  10'h010, 32'hBBBB1234, 32'h0,        1'b0, 0);
      applyStimulus("LW_mrg", 1'b0, F3_W,  10'h010, 32'h0,        32'h55AD1234, 1'b0, 0);

      // Misaligned and illegal accesses, none of which may touch the array
      applyStimulus("LW_12e", 1'b0, F3_W,  10'h012, 32'h0,        32'h0,        1'b1, 0);
      applyStimulus("SH_11e", 1'b1, F3_H,  10'h011, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
      applyStimulus("LD3e",   1'b0, 3'd3,  10'h010, 32'h0,        32'h0,        1'b1, 0);
      applyStimulus("ST4e",   1'b1, 3'd4,  10'h010, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
      applyStimulus("SW_11e", 1'b1, F3_W,  10'h011, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
      applyStimulus("LW_aft", 1'b0, F3_W,  10'h010, 32'h0,        32'h55AD1234, 1'b0, 0);

      // Response stalled for four cycles
      applyStimulus("LW_bp",  1'b0, F3_W,  10'h010, 32'h0,        32'h55AD1234, 1'b0, 4);

      // Store aborted by reset while waiting must not land
      applyStimulus("SW_20",  1'b1, F3_W,  10'h020, 32'h11223344, 32'h0,        1'b0, 0);
      bus.req_we     = 1'b1;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 10'h020;
      bus.req_wdata  = 32'hCAFEF00D;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort/in_wait", {31'd0, bus.req_ready}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort/req_ready", {31'd0, bus.req_ready}, 32'd1);
      checkOutput("abort/rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("abort/still_idle", {31'd0, bus.rsp_valid}, 32'd0);
      applyStimulus("LW_20",  1'b0, F3_W,  10'h020, 32'h0,        32'h11223344, 1'b0, 0);
      applyStimulus("LHU_22", 1'b0, F3_HU, 10'h022, 32'h0,        32'h00001122, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
